// File: rtl/debounce_scan_ctrl.sv
// Shared debounce engine: one sample-compare-count datapath scanned round-robin
// across N switch channels, with a one-deep press/release event slot.
module debounce_scan_ctrl #(
  parameter int N          = 4,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         sw_i,
  output logic [N-1:0]         sw_o,
  output logic                 tick,
  output logic [$clog2(N)-1:0] scan_ptr,
  output logic                 ev_valid,
  output logic [$clog2(N)-1:0] ev_chan,
  output logic                 ev_rise,
  input  logic                 ev_ready
);

  localparam int PTR_W = $clog2(N);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int CNT_W = ($clog2(STABLE_CNT) < 1) ? 1 : $clog2(STABLE_CNT);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt [N];

  logic             s_p;
  logic             o_p;
  logic [CNT_W-1:0] cnt_p;
  logic             differ;
  logic             at_last;
  logic             slot_free;
  logic             commit;

  assign tick = en && (pre == PRE_LAST);

  // Event handshake: an event transfers on a cycle where ev_valid && ev_ready.
  // ev_chan/ev_rise hold while ev_valid && !ev_ready; ev_ready alone is ignored.
  // The slot counts as free in the cycle it is being drained, so a commit
  // landing on a transfer cycle replaces the event with no bubble.
  always_comb begin
    s_p       = sync2[scan_ptr];
    o_p       = sw_o[scan_ptr];
    cnt_p     = cnt[scan_ptr];
    differ    = (s_p != o_p);
    at_last   = (cnt_p == CNT_LAST);
    slot_free = !ev_valid || ev_ready;
    commit    = tick && differ && at_last && slot_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_i;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  // A deferred commit leaves cnt parked at its last value so the next visit retries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr <= '0;
      sw_o     <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (tick) begin
      scan_ptr <= (scan_ptr == PTR_LAST) ? '0 : scan_ptr + 1'b1;
      if (!differ) begin
        cnt[scan_ptr] <= '0;
      end else if (!at_last) begin
        cnt[scan_ptr] <= cnt_p + 1'b1;
      end else if (slot_free) begin
        cnt[scan_ptr]  <= '0;
        sw_o[scan_ptr] <= s_p;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_chan  <= '0;
      ev_rise  <= 1'b0;
    end else if (commit) begin
      ev_valid <= 1'b1;
      ev_chan  <= scan_ptr;
      ev_rise  <= s_p;
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a visit-count model of the scanning debouncer.
module tb_debounce_scan_ctrl;
  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SC = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] sw_i;
  logic [N-1:0] sw_o;
  logic         tick;
  logic [1:0]   scan_ptr;
  logic         ev_valid;
  logic [1:0]   ev_chan;
  logic         ev_rise;
  logic         ev_ready;

  int total = 0;
  int bad   = 0;

  debounce_scan_ctrl #(.N(N), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clk(clk), .rst(rst), .en(en), .sw_i(sw_i), .sw_o(sw_o), .tick(tick),
    .scan_ptr(scan_ptr), .ev_valid(ev_valid), .ev_chan(ev_chan),
    .ev_rise(ev_rise), .ev_ready(ev_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit         h1 [N];
  bit         h2 [N];
  bit         m_out [N];
  int         m_cnt [N];
  int         m_pre;
  int         m_ptr;
  logic [2:0] m_slot [$];
  logic [2:0] exp_q  [$];
  logic [2:0] got_q  [$];

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      h1[i] = 0; h2[i] = 0; m_out[i] = 0; m_cnt[i] = 0;
    end
    m_pre = 0;
    m_ptr = 0;
    m_slot.delete();
  endtask

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_out[i];
    return v;
  endfunction

  function automatic bit m_tick();
    return en && (m_pre == TD - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    int p;
    bit t;
    if (rst) begin
      m_reset();
    end else begin
      t = m_tick();
      if (m_slot.size() != 0 && ev_ready) exp_q.push_back(m_slot.pop_front());
      if (t) begin
        p = m_ptr;
        if (h2[p] == m_out[p]) m_cnt[p] = 0;
        else if (m_cnt[p] < SC - 1) m_cnt[p] = m_cnt[p] + 1;
        else if (m_slot.size() == 0) begin
          m_out[p] = h2[p];
          m_cnt[p] = 0;
          m_slot.push_back({2'(p), h2[p]});
        end
        m_ptr = (m_ptr + 1) % N;
      end
      if (en) m_pre = (m_pre + 1) % TD;
      for (int i = 0; i < N; i++) begin
        h2[i] = h1[i];
        h1[i] = sw_i[i];
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("sw_o", int'(sw_o), int'(m_vec()));
      chk("tick", int'(tick), int'(m_tick()));
      chk("scan_ptr", int'(scan_ptr), m_ptr);
      chk("ev_valid", int'(ev_valid), int'(m_slot.size() != 0));
      if (m_slot.size() != 0) begin
        chk("ev_chan", int'(ev_chan), int'(m_slot[0][2:1]));
        chk("ev_rise", int'(ev_rise), int'(m_slot[0][0]));
      end
      if (ev_valid && ev_ready) got_q.push_back({ev_chan, ev_rise});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // waits at negedges until ev_valid, returns 0 on timeout
  task automatic wait_valid(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ev_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_sw(input int ch, input int limit, output int n, output bit ok);
    ok = 0;
    n  = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sw_o[ch] != 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int g0;
    int nt;
    rst = 1; en = 1; ev_ready = 1; sw_i = '0;
    step(3);
    rst = 0;

    // 1: async reset mid-run
    sw_i = 4'b1111;
    step(10);
    #2;
    rst = 1;
    #1;
    chk("rst_sw_o", int'(sw_o), 0);
    chk("rst_ev_valid", int'(ev_valid), 0);
    chk("rst_scan_ptr", int'(scan_ptr), 0);
    sw_i = '0;
    step(2);
    rst = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (tick) break;
    end
    chk("first_tick_clock", n, 4);

    // 2: clean press on ch2
    step(1);
    sw_i = 4'b0100;
    wait_sw(2, 100, n, ok);
    chk("press_seen", int'(ok), 1);
    chk("press_latency_in_range", int'(n >= 35 && n <= 2 + SC * N * TD), 1);
    chk("press_sw_o", int'(sw_o), 4);
    chk("press_ev_valid", int'(ev_valid), 1);
    chk("press_ev_chan", int'(ev_chan), 2);
    chk("press_ev_rise", int'(ev_rise), 1);
    @(negedge clk);
    chk("press_ev_one_cycle", int'(ev_valid), 0);

    // 3: bounce on ch1, two differing visits then one agreeing, five times
    step(1);
    g0 = got_q.size();
    for (int r = 0; r < 5; r++) begin
      sw_i[1] = 1'b1;
      step(32);
      sw_i[1] = 1'b0;
      step(16);
    end
    step(40);
    chk("bounce_sw_o", int'(sw_o), 4);
    chk("bounce_no_event", got_q.size(), g0);

    // 4: backpressure, ch0 held, ch3 deferred
    ev_ready = 0;
    g0 = got_q.size();
    sw_i[0] = 1'b1;
    wait_valid(80, ok);
    chk("bp_ev0_seen", int'(ok), 1);
    chk("bp_ev0_chan", int'(ev_chan), 0);
    chk("bp_ev0_rise", int'(ev_rise), 1);
    step(1);
    sw_i[3] = 1'b1;
    step(80);
    @(negedge clk);
    chk("bp_held_valid", int'(ev_valid), 1);
    chk("bp_held_chan", int'(ev_chan), 0);
    chk("bp_ch3_deferred", int'(sw_o[3]), 0);
    step(1);
    ev_ready = 1;
    step(1);
    ev_ready = 0;
    wait_valid(20, ok);
    chk("bp_ev3_seen", int'(ok), 1);
    chk("bp_ev3_chan", int'(ev_chan), 3);
    chk("bp_ev3_rise", int'(ev_rise), 1);
    chk("bp_ch3_sw_o", int'(sw_o[3]), 1);
    step(1);
    ev_ready = 1;
    step(3);
    chk("bp_event_count", got_q.size() - g0, 2);
    if (got_q.size() >= g0 + 2) begin
      chk("bp_order_first", int'(got_q[g0]), 3'b001);
      chk("bp_order_second", int'(got_q[g0 + 1]), 3'b111);
    end

    // 5: transfer and ch1 release commit on the same edge
    sw_i[1] = 1'b1;
    wait_sw(1, 100, n, ok);
    chk("sim_ch1_on", int'(ok), 1);
    step(1);
    ev_ready = 0;
    sw_i[0] = 1'b0;
    wait_valid(80, ok);
    chk("sim_ev0_seen", int'(ok), 1);
    step(1);
    sw_i[1] = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      ev_ready = m_tick() && m_ptr == 1 && h2[1] != m_out[1] && m_cnt[1] == SC - 1;
      if (ev_ready) begin
        @(negedge clk);
        chk("sim_pre_valid", int'(ev_valid), 1);
        chk("sim_pre_chan", int'(ev_chan), 0);
        @(negedge clk);
        chk("sim_post_valid", int'(ev_valid), 1);
        chk("sim_post_chan", int'(ev_chan), 1);
        chk("sim_post_rise", int'(ev_rise), 0);
        ok = 1;
        break;
      end
      step(1);
    end
    chk("sim_hit", int'(ok), 1);
    step(1);
    ev_ready = 1;
    step(3);

    // 6: scan disabled while inputs move
    en = 0;
    nt = 0;
    for (int i = 0; i < 50; i++) begin
      sw_i = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (tick) nt++;
      step(1);
    end
    chk("en_off_ticks", nt, 0);
    en = 1;
    sw_i = 4'b1010;
    step(120);

    // random traffic with one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 19) != 0);
      ev_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) sw_i[$urandom_range(0, N - 1)] ^= 1'b1;
      if (c == 1500) rst = 1;
      if (c == 1502) rst = 0;
      step(1);
    end
    en = 1;
    ev_ready = 1;
    step(40);

    chk("event_log_size", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("event_log_entry", int'(got_q[i]), int'(exp_q[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
Time-multiplexed debounce scheduler. One debounce engine (sample-compare-count) is shared across N switch inputs by round-robin scanning on a prescaled tick. It produces a debounced switch vector and a one-deep press/release event queue with a valid/ready handshake. It sits between raw board switches and the shift-register / user-logic stage, and replaces one debounce FSM per switch.

Parameters:
N, 4, number of switch channels (2..16)
TICK_DIV, 1000, clocks per scan step (>=2)
STABLE_CNT, 4, consecutive differing samples on a channel's visits needed to flip its output (2..15)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  scan enable; 0 freezes the prescaler, so no ticks occur
sw_i  input  N  raw asynchronous switch levels
sw_o  output  N  debounced switch levels
tick  output  1  one-cycle pulse marking a scan step
scan_ptr  output  $clog2(N)  channel serviced on the current tick
ev_valid  output  1  event pending
ev_chan  output  $clog2(N)  channel of the pending event
ev_rise  output  1  1 = 0->1 transition, 0 = 1->0 transition
ev_ready  input  1  consumer accepts the event

Behaviour:
- Reset (async, rst=1): sw_o=0, every cnt[i]=0, scan_ptr=0, prescaler=0, tick=0, synchronizers=0, ev_valid=0, ev_chan=0, ev_rise=0. Releasing reset mid-scan restarts everything from these values.
- Synchronizer: each sw_i bit passes through 2 flops to give s[i]. Only s is used downstream.
- Prescaler: counts 0..TICK_DIV-1 while en=1 and holds while en=0.
  - tick=1 for exactly one cycle when the prescaler equals TICK_DIV-1 and en=1.
  - The prescaler wraps to 0 on that cycle.
- Scan step on tick, with p=scan_ptr:
  - If s[p]==sw_o[p]: cnt[p]<=0.
  - Else if cnt[p]<STABLE_CNT-1: cnt[p]<=cnt[p]+1.
  - Else (cnt[p]==STABLE_CNT-1, i.e. the STABLE_CNTth consecutive differing visit): this is a commit.
    - If the slot is free (ev_valid=0, or ev_valid&&ev_ready this cycle): sw_o[p]<=s[p], cnt[p]<=0, ev_valid<=1, ev_chan<=p, ev_rise<=s[p].
    - Otherwise the commit is deferred: sw_o[p] and cnt[p] are held, and the commit is retried on the next visit to p. No event is ever lost or reordered per channel.
  - After the step, scan_ptr<=(p==N-1)?0:p+1. The pointer advances regardless of a deferral.
- Only channel p's cnt and sw_o change on a tick. All other channels hold.
- Event handshake:
  - Transfer occurs on ev_valid&&ev_ready.
  - ev_valid drops the next cycle unless a commit occurs in the same cycle, in which case ev_valid stays 1 with the new ev_chan/ev_rise.
  - ev_chan and ev_rise are stable while ev_valid=1 and ev_ready=0.
  - ev_ready with ev_valid=0 is ignored.
- Latency:
  - sw_o[i] flips at the clock edge of the STABLE_CNTth consecutive tick servicing i with s[i]!=sw_o[i].
  - ev_valid rises on that same edge.
  - With no deferral, the worst case from a stable sw_i change to sw_o is 2 + STABLE_CNT*N*TICK_DIV clocks.
- A glitch shorter than one visit period that is seen differing on fewer than STABLE_CNT consecutive visits produces no output change and no event. Any agreeing visit clears cnt to 0.
- Widths: cnt[i] is $clog2(STABLE_CNT) bits, minimum 1, and never exceeds STABLE_CNT-1. The prescaler is $clog2(TICK_DIV) bits.

Test Plan:
(Bench parameters: N=4, TICK_DIV=4, STABLE_CNT=3, so ticks fall every 4 clocks and each channel is visited every 16 clocks.)
1. Reset: assert rst mid-run with sw_i=4'b1111 -> sw_o=0, ev_valid=0, and scan_ptr=0 immediately, without waiting for a clock edge. After release, tick first fires on the 4th enabled clock.
2. Clean press: sw_i[2] goes 0->1 and is held, ev_ready=1 -> sw_o[2] goes 1 on the 3rd servicing tick of channel 2 (after 2-flop sync). The event appears as ev_valid=1, ev_chan=2, ev_rise=1 for 1 cycle. No other sw_o bit changes.
3. Bounce: sw_i[1] toggles so it is seen differing on 2 visits, then agreeing on 1, repeated 5 times -> sw_o[1] stays 0 and ev_valid never rises.
4. Backpressure: ev_ready=0; press ch0, then ch3 -> the ch0 event is held (chan=0, rise=1) and ch3's commit is deferred with sw_o[3]=0. Raise ev_ready for 1 cycle -> the ch3 event appears on ch3's next visit. The consumer sees exactly 2 events, in order 0 then 3.
5. Simultaneous: ev_valid&&ev_ready on the same cycle as a commit for ch1 release -> ev_valid stays 1, ev_chan=1, ev_rise=0, and no bubble cycle.
6. Enable: en=0 for 50 clocks while sw_i changes -> tick=0, scan_ptr frozen, sw_o unchanged. Resume en=1 -> scanning continues from the frozen scan_ptr.
